sa_result_drain: RTL and testbench
==================================

Name: sa_result_drain

Overview:
- Sits directly downstream of the systolic-array tile driver / `systolic_array_os` pair.
- On the tile-complete pulse it snapshots the full M×N FP32 accumulator array (`c_out_flat` / `c_valid_flat`).
- It then drains the snapshot row by row over a valid/ready write stream toward the output buffer or memory, one row of N results per beat.
- It reports completion, incomplete-result errors and overruns.

Parameters:
- M, 8, rows of the systolic array (number of write beats per tile)
- N, 8, columns of the systolic array (FP32 words per beat)
- ADDR_W, 16, width of row addresses

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- tile_done  in  1  one-cycle pulse from the tile driver: `c_out_flat` / `c_valid_flat` are final
- c_out_flat  in  M*N*32  accumulator array; element (i,j) at bits [(i*N+j)*32 +: 32]
- c_valid_flat  in  M*N  per-element valid; element (i,j) at bit i*N+j
- base_addr  in  ADDR_W  row-0 destination address, sampled with tile_done
- row_stride  in  ADDR_W  address increment per row, sampled with tile_done
- drain_busy  out  1  high while a snapshot is held or being drained
- drain_done  out  1  one-cycle pulse after the last row is accepted
- drain_err  out  1  one-cycle pulse: captured `c_valid_flat` was not all-ones
- drain_overrun  out  1  one-cycle pulse: tile_done arrived while not IDLE
- wr_valid  out  1  write beat valid
- wr_addr  out  ADDR_W  destination address of the current row
- wr_data  out  N*32  current row; word j at bits [j*32 +: 32]
- wr_mask  out  N  per-word valid mask, equal to `c_valid_flat[row*N +: N]` of the snapshot
- wr_ready  in  1  sink accepts the beat when wr_valid && wr_ready

Behaviour:
- Reset (asynchronous, rst_n=0): st=IDLE, row=0, addr_reg=0.
  - Snapshot registers are cleared.
  - All outputs are 0: drain_busy, drain_done, drain_err, drain_overrun, wr_valid, wr_addr, wr_data, wr_mask.
  - Reset mid-drain abandons the tile: no drain_done, wr_valid drops immediately.
- All outputs are registered; none depends combinationally on wr_ready or tile_done.
- States: IDLE, DRAIN, DONE.
- IDLE:
  - drain_busy=0.
  - On tile_done=1: snapshot c_out_flat, c_valid_flat, base_addr and row_stride; row=0; addr_reg=base_addr; go to DRAIN.
  - drain_err pulses in the cycle after capture iff the captured `c_valid_flat` is not all-ones. The drain still proceeds, and masks carry the gaps.
- DRAIN:
  - drain_busy=1, wr_valid=1.
  - wr_data = snapshot row[row], wr_mask = snapshot mask[row], wr_addr = addr_reg.
  - Beat accepted when wr_valid && wr_ready. On acceptance:
    - if row==M-1, go to DONE;
    - otherwise row+=1 and addr_reg += row_stride, wrapping modulo 2^ADDR_W.
  - While wr_ready=0, wr_valid, wr_addr, wr_data and wr_mask must stay stable. Valid is never withdrawn without acceptance.
- DONE (one cycle): wr_valid=0, drain_busy=1, drain_done=1; then go to IDLE.
- Latency: tile_done sampled at edge T gives wr_valid=1 with row 0 from cycle T+1.
  - With wr_ready held at 1, rows 0..M-1 appear on cycles T+1..T+M.
  - drain_done is high on cycle T+M+1; IDLE resumes at T+M+2.
  - Back-to-back tiles therefore need tile_done spacing of at least M+2 cycles.
- tile_done while in DRAIN or DONE:
  - it is ignored;
  - the snapshot is not overwritten;
  - drain_overrun pulses for one cycle.
- Snapshot isolation: changes on c_out_flat, c_valid_flat, base_addr or row_stride after capture have no effect on the tile in flight.
- Address arithmetic: unsigned, ADDR_W bits, modular. row_stride=0 is legal (all rows go to base_addr).
- M=1: DRAIN issues a single beat, then DONE.

Test Plan:
- Nominal:
  - Stimulus: M=N=8, c_out(i,j)=32'h3F800000+i*8+j, all valid, base=16'h0100, stride=16'h0020, wr_ready=1.
  - Response: 8 beats on consecutive cycles, addresses 0x0100, 0x0120, …, 0x01E0; data words match; mask 8'hFF; drain_done exactly 1 cycle after the last beat; drain_err never asserted.
- Backpressure:
  - Stimulus: wr_ready toggles pseudo-randomly, including a 5-cycle low stretch on row 3.
  - Response: beat contents held stable while stalled; each row accepted exactly once and in order; drain_done only after row 7 is accepted.
- Partial validity:
  - Stimulus: c_valid bit (2,5)=0.
  - Response: drain_err pulses once after capture; row 2 carries mask 8'hDF; all other rows carry 8'hFF.
- Overrun and isolation:
  - Stimulus: second tile_done during row 4 with different data; change c_out_flat mid-drain.
  - Response: drain_overrun pulses once; all beats carry the first snapshot.
- Wrap and reset:
  - Stimulus: base=16'hFFF0, stride=16'h0008.
  - Response: addresses FFF0, FFF8, 0000, 0008, …
  - Stimulus: then assert rst_n=0 during row 2.
  - Response: all outputs go to 0 asynchronously; no drain_done; a fresh tile after reset drains correctly from row 0.

Source files
------------

// File: rtl/sa_result_drain.sv
// sa_result_drain
// Captures the M x N FP32 accumulator array of the systolic array when the
// tile driver pulses tile_done, then streams the snapshot out one row per
// valid/ready beat (N words per beat) toward the output buffer.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   tile_done                  pulse: c_out_flat / c_valid_flat are final
//   c_out_flat, c_valid_flat   accumulator array and per-element valid
//   base_addr, row_stride      row-0 address and per-row increment
//   drain_busy                 snapshot held or being drained
//   drain_done                 pulse after the last row is accepted
//   drain_err                  pulse: captured valid bits not all ones
//   drain_overrun              pulse: tile_done arrived while not idle
//   wr_valid/wr_ready          write stream handshake
//   wr_addr, wr_data, wr_mask  current row beat
//
// state | meaning
// IDLE  | waiting for tile_done, no snapshot held
// DRAIN | presenting snapshot row r_row until the sink accepts it
// DONE  | single cycle, drain_done asserted, then back to IDLE
module sa_result_drain #(
    parameter int M      = 8,
    parameter int N      = 8,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tile_done,
    input  logic [M*N*32-1:0]   c_out_flat,
    input  logic [M*N-1:0]      c_valid_flat,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   row_stride,
    output logic                drain_busy,
    output logic                drain_done,
    output logic                drain_err,
    output logic                drain_overrun,
    output logic                wr_valid,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [N*32-1:0]     wr_data,
    output logic [N-1:0]        wr_mask,
    input  logic                wr_ready
);

    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ROW_W-1:0]    r_row;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_stride;
    logic [N*32-1:0]     r_snap_data [M];
    logic [N-1:0]        r_snap_mask [M];
    logic                r_err;
    logic                r_overrun;

    logic w_capture;
    logic w_accept;
    logic w_last;

    assign w_capture = (r_state == IDLE) && tile_done;
    assign w_accept  = (r_state == DRAIN) && wr_ready;
    assign w_last    = (r_row == ROW_W'(M - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (tile_done) w_next = DRAIN;
            DRAIN:   if (wr_ready && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Snapshot is only written from IDLE, so a tile_done that lands during
    // DRAIN/DONE cannot disturb the tile in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row     <= '0;
            r_addr    <= '0;
            r_stride  <= '0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < M; i++) begin
                r_snap_data[i] <= '0;
                r_snap_mask[i] <= '0;
            end
        end else begin
            r_err     <= w_capture && !(&c_valid_flat);
            r_overrun <= tile_done && (r_state != IDLE);
            if (w_capture) begin
                r_row    <= '0;
                r_addr   <= base_addr;
                r_stride <= row_stride;
                for (int i = 0; i < M; i++) begin
                    r_snap_data[i] <= c_out_flat[i*N*32 +: N*32];
                    r_snap_mask[i] <= c_valid_flat[i*N +: N];
                end
            end else if (w_accept && !w_last) begin
                r_row  <= r_row + 1'b1;
                r_addr <= r_addr + r_stride;
            end
        end
    end

    // Beat outputs come straight from registers and are forced to zero
    // outside DRAIN so the bus is quiet whenever wr_valid is low.
    assign wr_valid      = (r_state == DRAIN);
    assign drain_busy    = (r_state != IDLE);
    assign drain_done    = (r_state == DONE);
    assign drain_err     = r_err;
    assign drain_overrun = r_overrun;
    assign wr_addr       = wr_valid ? r_addr : '0;
    assign wr_data       = wr_valid ? r_snap_data[r_row] : '0;
    assign wr_mask       = wr_valid ? r_snap_mask[r_row] : '0;

endmodule

// File: tb/tb_sa_result_drain.sv
module tb_sa_result_drain;

    localparam int M = 8;
    localparam int N = 8;
    localparam int AW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tile_done = 1'b0;
    logic [M*N*32-1:0] c_out_flat = '0;
    logic [M*N-1:0]    c_valid_flat = '0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW-1:0]     row_stride = '0;
    logic              drain_busy, drain_done, drain_err, drain_overrun;
    logic              wr_valid;
    logic [AW-1:0]     wr_addr;
    logic [N*32-1:0]   wr_data;
    logic [N-1:0]      wr_mask;
    logic              wr_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    // expected snapshot of the tile in flight
    logic [31:0]    exp_seed;
    logic [M*N-1:0] exp_valid;
    logic [AW-1:0]  exp_base;
    logic [AW-1:0]  exp_stride;

    sa_result_drain #(.M(M), .N(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .tile_done(tile_done),
        .c_out_flat(c_out_flat), .c_valid_flat(c_valid_flat),
        .base_addr(base_addr), .row_stride(row_stride),
        .drain_busy(drain_busy), .drain_done(drain_done),
        .drain_err(drain_err), .drain_overrun(drain_overrun),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [M*N*32-1:0] mk_array(input logic [31:0] seed);
        logic [M*N*32-1:0] v;
        for (int k = 0; k < M*N; k++) v[k*32 +: 32] = seed + 32'(k);
        return v;
    endfunction

    function automatic logic [N*32-1:0] exp_row(input int r);
        logic [N*32-1:0] v;
        for (int j = 0; j < N; j++) v[j*32 +: 32] = exp_seed + 32'(r*N + j);
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  drain_busy, 0);
        check({tag, "_done"},  drain_done, 0);
        check({tag, "_err"},   drain_err, 0);
        check({tag, "_ovr"},   drain_overrun, 0);
        check({tag, "_valid"}, wr_valid, 0);
        check({tag, "_addr"},  wr_addr, 0);
        check({tag, "_data"},  wr_data, 0);
        check({tag, "_mask"},  wr_mask, 0);
    endtask

    // called at a negedge; returns at the negedge after tile_done is sampled
    task automatic start_tile(input logic [31:0] seed, input logic [M*N-1:0] valid,
                              input logic [AW-1:0] base, input logic [AW-1:0] stride);
        exp_seed = seed; exp_valid = valid; exp_base = base; exp_stride = stride;
        c_out_flat = mk_array(seed);
        c_valid_flat = valid;
        base_addr = base;
        row_stride = stride;
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
    endtask

    // mode 0: wr_ready always 1; mode 1: random with 5-cycle stall on row 3
    // inj_row: row during which a second tile_done with new data is injected
    // abort_row: row during which reset is asserted (drain abandoned)
    task automatic drain(input string tag, input int mode, input int inj_row,
                         input int abort_row, input int exp_err, input int exp_ovr);
        int r = 0, cyc = 0, stall = 0, n_err = 0, n_ovr = 0;
        bit injected = 0;
        bit rdy;
        logic [AW-1:0] a;
        while (r < M && cyc < 200) begin
            tile_done = 1'b0;
            if (drain_err) n_err++;
            if (drain_overrun) n_ovr++;
            if (r == abort_row) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero({tag, "_async_rst"});
                wr_ready = 1'b0;
                return;
            end
            a = exp_base + AW'(r) * exp_stride;
            check({tag, "_valid"}, wr_valid, 1);
            check({tag, "_busy"},  drain_busy, 1);
            check({tag, "_done_early"}, drain_done, 0);
            check({tag, "_addr"},  wr_addr, a);
            check({tag, "_data"},  wr_data, exp_row(r));
            check({tag, "_mask"},  wr_mask, exp_valid[r*N +: N]);
            if (r == inj_row && !injected) begin
                injected = 1;
                tile_done = 1'b1;
                c_out_flat = mk_array(32'hDEAD0000);
                c_valid_flat = '0;
                base_addr = 16'h7777;
                row_stride = 16'h0001;
            end
            if (mode == 1 && r == 3 && stall < 5) begin
                rdy = 0;
                stall++;
            end else if (mode == 1) begin
                rdy = ($urandom_range(0, 1) == 1);
            end else begin
                rdy = 1;
            end
            wr_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) r++;
        end
        tile_done = 1'b0;
        wr_ready = 1'b0;
        check({tag, "_rows_accepted"}, r, M);
        if (mode == 0) check({tag, "_cycles"}, cyc, M);
        if (drain_err) n_err++;
        if (drain_overrun) n_ovr++;
        check({tag, "_done_pulse"}, drain_done, 1);
        check({tag, "_done_valid"}, wr_valid, 0);
        check({tag, "_done_busy"},  drain_busy, 1);
        @(negedge clk);
        if (drain_err) n_err++;
        if (drain_overrun) n_ovr++;
        check({tag, "_idle_done"}, drain_done, 0);
        check({tag, "_idle_busy"}, drain_busy, 0);
        check({tag, "_err_pulses"}, n_err, exp_err);
        check({tag, "_ovr_pulses"}, n_ovr, exp_ovr);
    endtask

    initial begin
        logic [M*N-1:0] part;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        start_tile(32'h3F800000, '1, 16'h0100, 16'h0020);
        drain("nominal", 0, -1, -1, 0, 0);

        start_tile(32'h40000000, '1, 16'h0200, 16'h0040);
        drain("backpr", 1, -1, -1, 0, 0);

        part = '1;
        part[2*N + 5] = 1'b0;
        start_tile(32'h41000000, part, 16'h0300, 16'h0010);
        drain("partial", 0, -1, -1, 1, 0);

        start_tile(32'h42000000, '1, 16'h0400, 16'h0020);
        drain("overrun", 0, 4, -1, 0, 1);

        start_tile(32'h43000000, '1, 16'hFFF0, 16'h0008);
        drain("wrap", 0, -1, 2, 0, 0);
        repeat (2) begin
            @(negedge clk);
            check_all_zero("in_reset");
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_all_zero("after_reset");
        end

        start_tile(32'h44000000, '1, 16'h0040, 16'h0000);
        drain("fresh", 0, -1, -1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
